// File: rtl/coin_acceptor.sv
// Coin sensor front end for the vending FSM: synchronises and debounces two
// coin sensors and issues one i/j code per accepted coin. Coins wait while hold is high.
module coin_acceptor #(
  parameter int DB_CYCLES = 4,
  parameter int CW        = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic coin5_raw,
  input  logic coin10_raw,
  input  logic hold,
  output logic i,
  output logic j,
  output logic coin_reject
);

  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Bit 0 is the 5-unit channel and bit 1 is the 10-unit channel.
  logic [1:0]         raw_s;
  logic [1:0]         meta_r;
  logic [1:0]         sync_r;
  logic [1:0]         deb_r;
  logic [1:0]         deb_nxt_s;
  logic [1:0][CW-1:0] cnt_r;
  logic [1:0][CW-1:0] cnt_nxt_s;
  logic [1:0]         event_s;
  logic [1:0]         clear_s;
  logic [1:0]         ovf_s;
  logic [1:0]         pend_r;
  logic [1:0]         pend_nxt_s;
  logic               reject_nxt_s;
  logic               reject_r;

  assign raw_s = {coin10_raw, coin5_raw};

  // Two-flop synchroniser for each channel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_r <= 2'b00;
      sync_r <= 2'b00;
    end else begin
      meta_r <= raw_s;
      sync_r <= meta_r;
    end
  end

  // Debounce next state: a level change needs DB_CYCLES consecutive disagreeing samples.
  always_comb begin
    deb_nxt_s = deb_r;
    cnt_nxt_s = '0;
    for (int c = 0; c < 2; c++) begin
      if (sync_r[c] == deb_r[c]) begin
        cnt_nxt_s[c] = '0;
      end else if (cnt_r[c] == CNT_LAST) begin
        deb_nxt_s[c] = sync_r[c];
        cnt_nxt_s[c] = '0;
      end else begin
        cnt_nxt_s[c] = cnt_r[c] + CNT_ONE;
      end
    end
  end

  // Pending-flag and reject logic. The 10-unit coin is always issued before the 5-unit coin.
  always_comb begin
    event_s      = ~deb_r & deb_nxt_s;
    clear_s[1]   = ~hold & pend_r[1];
    clear_s[0]   = ~hold & pend_r[0] & ~pend_r[1];
    // A coin arriving while its flag is still held cannot be stored and is dropped.
    ovf_s        = event_s & pend_r & ~clear_s;
    pend_nxt_s   = event_s | (pend_r & ~clear_s);
    reject_nxt_s = |ovf_s;
  end

  // Debounce, pending and reject state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_r    <= 2'b00;
      cnt_r    <= '0;
      pend_r   <= 2'b00;
      reject_r <= 1'b0;
    end else begin
      deb_r    <= deb_nxt_s;
      cnt_r    <= cnt_nxt_s;
      pend_r   <= pend_nxt_s;
      reject_r <= reject_nxt_s;
    end
  end

  // i and j stay combinational so that a coin is issued in the same cycle that hold falls.
  assign i           = ~hold & (pend_r[0] | pend_r[1]);
  assign j           = ~hold & pend_r[1];
  assign coin_reject = reject_r;

endmodule
